key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Front-end conditioning for the five push-buttons; sits directly upstream of the control FSM and the data register.
- Synchronises each raw key to clk100mhz and debounces it with a per-key stability counter.
- Emits a clean level per key, a single-cycle press pulse and a single-cycle release pulse.
- Downstream logic consumes press pulses only; it never sees raw pins.

Parameters:
- N_KEYS, 5, number of independent key channels.
- DEB_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DEB_CYCLES.
- REPEAT_DELAY, 50000000, hold cycles before the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 20000000, cycles between subsequent repeat pulses (used only with the optional feature).

Ports:
- clk100mhz  input  1  system clock, 100 MHz.
- clr  input  1  reset, asynchronous, active-high.
- key_in  input  N_KEYS  raw active-high buttons, asynchronous to clk100mhz.
- key_level  output  N_KEYS  debounced level per key.
- key_press  output  N_KEYS  one-cycle pulse on accepted 0->1 transition.
- key_release  output  N_KEYS  one-cycle pulse on accepted 1->0 transition.
- any_press  output  1  OR of key_press, registered in the same cycle as key_press.

Behaviour:
- Reset state (clr high, async): synchroniser flops = 0, counters = 0, key_level = 0, key_press = 0, key_release = 0, any_press = 0.
- Synchroniser: two flops per key. sync = second-stage output.
- Per-key counter, evaluated each cycle:
  - sync == key_level: counter <= 0.
  - sync != key_level and counter < DEB_CYCLES-1: counter <= counter+1.
  - sync != key_level and counter == DEB_CYCLES-1: key_level <= sync, counter <= 0.
- Pulses:
  - key_press[i] = 1 for exactly the one cycle in which key_level[i] is updated 0->1.
  - key_release[i] = 1 for exactly the one cycle in which key_level[i] is updated 1->0.
  - All pulse outputs are registered and change on the same edge as key_level.
- Latency: a clean input step is visible on key_level/key_press 2 + DEB_CYCLES clock edges after the first edge that samples the new value.
- Glitch rejection: any excursion shorter than DEB_CYCLES cycles (post-synchroniser) resets the counter and produces no level change and no pulse.
- Channels are fully independent; simultaneous presses on several keys each produce their own pulse in the same cycle.
- Reset mid-debounce: the counter is discarded. A key held through clr deassertion is treated as a new press and pulses after the full latency.
- Counter never exceeds DEB_CYCLES-1; no wrap-around.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - Per key, a hold counter runs while key_level = 1.
  - After REPEAT_DELAY cycles of continuous hold, key_press re-pulses for one cycle, then again every REPEAT_PERIOD cycles.
  - The hold counter clears on release or reset.
  - any_press follows these repeat pulses.
- Undefined: no hold counters are built; exactly one key_press per accepted press.

Decomposition:
- Shared package key_pkg:
  - N_KEYS default.
  - Key index constants KEY_CENTER=0, KEY_UP=1, KEY_LEFT=2, KEY_RIGHT=3, KEY_DOWN=4.
  - DEB_CYCLES default.
  - Simulation override constant DEB_CYCLES_SIM=4.
- Sub-module key_debounce_cell: one-bit synchroniser, counter, level register and pulse generation (plus the repeat counter when KEY_AUTO_REPEAT_EN is defined). Generated N_KEYS times by key_conditioner.

Test Plan (DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Hold key_in=5'b00001 from reset release -> key_level[0] rises and key_press[0]=1 for one cycle, 6 edges after key_in sampled; any_press=1 in that cycle.
- Pulse key_in[1] high for 3 cycles, then low -> key_level[1] stays 0; no key_press or key_release.
- Press key 2 stably, then release stably -> one key_press[2], later one key_release[2], each exactly one cycle wide.
- Raise key_in=5'b10010 on the same cycle -> key_press[4] and key_press[1] assert in the same cycle; other bits 0.
- Assert clr mid-debounce of key 3 with key still held, release clr -> all outputs 0 during clr; key_press[3] appears 6 edges after clr falls.
- With KEY_AUTO_REPEAT_EN, hold key 0 for 40 cycles after acceptance -> key_press[0] pulses at acceptance, +10, +15, +20, +25, +30, +35 cycles; none after release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and payload types for the push-button conditioning slice.
package key_pkg;

    localparam int unsigned N_KEYS_DEF     = 5;
    localparam int unsigned DEB_CYCLES_DEF = 1000000;
    localparam int unsigned DEB_CYCLES_SIM = 4;
    localparam int unsigned CNT_W_DEF      = 20;

    // Board key positions within key_in / key_level
    localparam int unsigned KEY_CENTER = 0;
    localparam int unsigned KEY_UP     = 1;
    localparam int unsigned KEY_LEFT   = 2;
    localparam int unsigned KEY_RIGHT  = 3;
    localparam int unsigned KEY_DOWN   = 4;

    // Registered per-key result of one debounce cell
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
    } key_evt_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One key channel: two-flop synchroniser, stability counter, level and edge pulses.
// KEY_AUTO_REPEAT_EN adds a hold counter that re-pulses press while the key stays down.
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
`ifdef KEY_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 20000000
`endif
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     key_raw,
    output key_evt_t evt,
    output logic     press_c
);

    logic [1:0]       sync_q;
    logic             sync;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;
    logic             release_c;

    assign sync = sync_q[1];

    // Synchroniser chain into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);

    logic [RPT_W-1:0] rpt_q;
    logic [RPT_W-1:0] rpt_d;
    logic             rpt_pulse_c;

    // Hold timer: first re-pulse after REPEAT_DELAY, then reloads to space pulses by REPEAT_PERIOD
    always_comb begin
        rpt_d       = '0;
        rpt_pulse_c = 1'b0;
        if (evt.level && level_d) begin
            if (rpt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                rpt_pulse_c = 1'b1;
                rpt_d       = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    // Stability counter: a level is accepted only after DEB_CYCLES consecutive differing samples
    always_comb begin
        cnt_d     = '0;
        level_d   = evt.level;
        press_c   = 1'b0;
        release_c = 1'b0;
        if (sync != evt.level) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d   = sync;
                press_c   = sync;
                release_c = ~sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`ifdef KEY_AUTO_REPEAT_EN
        if (rpt_pulse_c) begin
            press_c = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            evt   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            evt.level <= level_d;
            evt.press <= press_c;
            evt.rel   <= release_c;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Five-channel push-button front end: debounced levels, press/release pulses and any_press.
// Optional auto-repeat of press pulses is built when KEY_AUTO_REPEAT_EN is defined.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS        = N_KEYS_DEF,
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 20000000
) (
    input  logic              clk100mhz,
    input  logic              clr,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              any_press
);

    localparam bit CFG_OK = (DEB_CYCLES >= 2)
                         && ((64'(1) << CNT_W) > 64'(DEB_CYCLES))
                         && (REPEAT_PERIOD >= 1)
                         && (REPEAT_PERIOD <= REPEAT_DELAY);

    // Reject parameter sets the counters cannot represent
    if (!CFG_OK) begin : g_bad_cfg
        $error("key_conditioner: illegal DEB_CYCLES/CNT_W/REPEAT_* combination");
    end

    key_evt_t          evt   [N_KEYS];
    logic [N_KEYS-1:0] press_nxt_c;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEB_CYCLES    (DEB_CYCLES),
            .CNT_W         (CNT_W)
`ifdef KEY_AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_cell (
            .clk     (clk100mhz),
            .rst     (clr),
            .key_raw (key_in[i]),
            .evt     (evt[i]),
            .press_c (press_nxt_c[i])
        );

        assign key_level[i]   = evt[i].level;
        assign key_press[i]   = evt[i].press;
        assign key_release[i] = evt[i].rel;
    end

    // any_press is registered from the same next-state terms as key_press
    always_ff @(posedge clk100mhz or posedge clr) begin
        if (clr) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_nxt_c;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: directed scenarios then randomized key activity.
module tb_key_conditioner;

    localparam int unsigned NK  = 5;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 5;

    typedef struct packed {
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic          any;
    } exp_t;

    logic          clk100mhz = 1'b0;
    logic          clr       = 1'b1;
    logic [NK-1:0] key_in    = '0;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          any_press;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t exp_q[$];

    key_conditioner #(
        .N_KEYS        (NK),
        .DEB_CYCLES    (key_pkg::DEB_CYCLES_SIM),
        .CNT_W         (3),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk100mhz   (clk100mhz),
        .clr         (clr),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .any_press   (any_press)
    );

    always #5 clk100mhz = ~clk100mhz;

    // Reference: raw samples reach the counter two edges late; a level flips once the last
    // DEB synchronised samples all disagree with it. Repeat timing is measured from acceptance.
    logic [NK-1:0] raw_hist[$];
    logic [NK-1:0] sync_hist[$];
    logic [NK-1:0] m_lvl;
    int            acc_t[NK];
    int            t_edge;

    task automatic model_reset();
        raw_hist.delete();
        raw_hist.push_back('0);
        raw_hist.push_back('0);
        sync_hist.delete();
        m_lvl = '0;
    endtask

    task automatic model_edge(input logic [NK-1:0] k, input logic c, output exp_t e);
        logic [NK-1:0] s;
        bit            all_diff;
        e = '0;
        t_edge++;
        if (c) begin
            model_reset();
            return;
        end
        s = raw_hist[0];
        raw_hist.push_back(k);
        void'(raw_hist.pop_front());
        sync_hist.push_back(s);
        if (sync_hist.size() > DEB) void'(sync_hist.pop_front());
        for (int i = 0; i < NK; i++) begin
            all_diff = (sync_hist.size() == DEB);
            foreach (sync_hist[j]) if (sync_hist[j][i] == m_lvl[i]) all_diff = 0;
            if (all_diff) begin
                if (!m_lvl[i]) begin
                    e.press[i] = 1'b1;
                    acc_t[i]   = t_edge;
                end else begin
                    e.rel[i] = 1'b1;
                end
                m_lvl[i] = ~m_lvl[i];
            end
`ifdef KEY_AUTO_REPEAT_EN
            else if (m_lvl[i]) begin
                int age;
                age = t_edge - acc_t[i];
                if (age >= int'(RD) && ((age - int'(RD)) % int'(RP)) == 0) e.press[i] = 1'b1;
            end
`endif
        end
        e.level = m_lvl;
        e.any   = |e.press;
    endtask

    // Drive one cycle of stimulus and queue the response expected at the next rising edge
    task automatic step(input logic [NK-1:0] k, input logic c);
        exp_t e;
        @(negedge clk100mhz);
        key_in = k;
        clr    = c;
        model_edge(k, c, e);
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [NK-1:0] k, input int n);
        for (int i = 0; i < n; i++) step(k, 1'b0);
    endtask

    task automatic cmp(input string name, input logic [NK-1:0] got, input logic [NK-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, want);
        end
    endtask

    // Monitor: every edge the DUT presents a fresh output set; compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk100mhz);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp("key_level",   key_level,   e.level);
                cmp("key_press",   key_press,   e.press);
                cmp("key_release", key_release, e.rel);
                cmp("any_press",   {{(NK-1){1'b0}}, any_press}, {{(NK-1){1'b0}}, e.any});
            end
        end
    end

    initial begin
        logic [NK-1:0] kv;
        int            remain[NK];
        int            clr_left;
        int            guard;

        model_reset();
        t_edge = 0;

        // Key 0 held through reset release
        step(5'b00001, 1'b1);
        step(5'b00001, 1'b1);
        hold(5'b00001, 10);
        hold(5'b00000, 10);
        // Short excursion on key 1 is rejected
        hold(5'b00010, 3);
        hold(5'b00000, 10);
        // Clean press and release of key 2
        hold(5'b00100, 10);
        hold(5'b00000, 10);
        // Simultaneous keys 4 and 1
        hold(5'b10010, 10);
        hold(5'b00000, 10);
        // Reset in the middle of key 3 debounce, key kept down
        hold(5'b01000, 3);
        step(5'b01000, 1'b1);
        step(5'b01000, 1'b1);
        hold(5'b01000, 12);
        hold(5'b00000, 10);
        // Long hold on key 0 (exercises auto-repeat when built)
        hold(5'b00001, 50);
        hold(5'b00000, 15);

        // Randomized per-key toggling with durations around the debounce boundary
        kv = '0;
        for (int i = 0; i < NK; i++) remain[i] = $urandom_range(1, 8);
        clr_left = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NK; i++) begin
                if (remain[i] == 0) begin
                    kv[i]     = ~kv[i];
                    remain[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 30)
                                                             : $urandom_range(1, 8);
                end
                remain[i]--;
            end
            if (clr_left == 0 && $urandom_range(0, 199) == 0) clr_left = $urandom_range(1, 2);
            step(kv, clr_left != 0);
            if (clr_left != 0) clr_left--;
        end
        hold(5'b00000, 10);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk100mhz);
            guard++;
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
